seq_main_controller: RTL and testbench

- Parametrised successor to the matrix-multiply main controller.
- Sequences a runtime-selectable number of row multiplications: presents a row result address, holds begin_mult, and advances on each row-completion edge from the multiply datapath.
- Signals completion with a done_calc / out_ack handshake.
- Sits between the input-storage block (data_stored) and the row multiplier / result writer.

---
 rtl/seq_main_ctrl_pkg.sv | 19 +
 rtl/seq_row_counter.sv | 46 ++++
 rtl/seq_main_controller.sv | 152 +++++++++++++++
 tb/tb_seq_main_controller.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_main_ctrl_pkg.sv
// Shared types and helpers for the row-sequencing main controller.
package seq_main_ctrl_pkg;

    localparam int unsigned DEFAULT_MAX_ROWS = 10;
    localparam int unsigned DEFAULT_ADDR_W   = 4;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StMul,
        StMulDone,
        StWriteOut
    } state_t;

    function automatic logic row_count_ok(input int unsigned count, input int unsigned max_rows);
        return (count >= 1) && (count <= max_rows);
    endfunction

endpackage

// File: rtl/seq_row_counter.sv
// done_row edge detector and row counter with terminal compare.
module seq_row_counter
    import seq_main_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              done_row,
    input  logic              clear,
    input  logic              enable,
    input  logic [ADDR_W-1:0] rows_m1,
    output logic              row_evt,
    output logic [ADDR_W-1:0] count,
    output logic              last_row
);

    logic              done_row_q;
    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] count_d;

    // A level held high for several cycles counts as a single row completion.
    assign row_evt  = done_row & ~done_row_q;
    assign last_row = (count_q == rows_m1);
    assign count    = count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && row_evt) begin
            count_d = last_row ? '0 : count_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            done_row_q <= 1'b0;
            count_q    <= '0;
        end else begin
            done_row_q <= done_row;
            count_q    <= count_d;
        end
    end

endmodule

// File: rtl/seq_main_controller.sv
// Main controller: sequences row multiplications and hands the result to the writer.
// Optional per-row watchdog enabled by defining SEQ_MAIN_CTRL_ROW_TIMEOUT_EN.
module seq_main_controller
    import seq_main_ctrl_pkg::*;
#(
    parameter int unsigned MAX_ROWS    = DEFAULT_MAX_ROWS,
    parameter int unsigned ADDR_W      = DEFAULT_ADDR_W,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              data_stored,
    input  logic [ADDR_W-1:0] row_count,
    input  logic              done_row,
    input  logic              abort,
    input  logic              out_ack,
    output logic [ADDR_W-1:0] res_add,
    output logic              begin_mult,
    output logic              done_calc,
    output logic              busy,
    output logic              cfg_err
`ifdef SEQ_MAIN_CTRL_ROW_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    if (MAX_ROWS < 1 || MAX_ROWS > 2 ** ADDR_W) begin : g_bad_max_rows
        $error("MAX_ROWS must lie in 1..2**ADDR_W");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] rows_m1_q;
    logic [ADDR_W-1:0] rows_m1_d;
    logic              cfg_err_q;
    logic              cfg_err_d;
    logic              start_ok;
    logic              start_acc;
    logic              row_evt;
    logic              last_row;
    logic [ADDR_W-1:0] row_idx;
    logic              cnt_clear;
    logic              timeout_hit;

    assign start_ok  = row_count_ok(32'(row_count), MAX_ROWS);
    assign start_acc = (state_q == StIdle) && data_stored && start_ok;
    assign cnt_clear = (state_q != StMul) || abort || timeout_hit;

    seq_row_counter #(
        .ADDR_W (ADDR_W)
    ) u_row_counter (
        .clk      (clk),
        .n_reset  (n_reset),
        .done_row (done_row),
        .clear    (cnt_clear),
        .enable   (state_q == StMul),
        .rows_m1  (rows_m1_q),
        .row_evt  (row_evt),
        .count    (row_idx),
        .last_row (last_row)
    );

`ifdef SEQ_MAIN_CTRL_ROW_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_q;
    logic [WD_W-1:0] wd_d;
    logic            timeout_err_q;
    logic            timeout_err_d;

    // A row event on the limit cycle wins over the timeout.
    assign timeout_hit = (state_q == StMul) && !row_evt && (wd_q == WD_W'(TIMEOUT_CYC - 1));

    always_comb begin
        wd_d          = '0;
        timeout_err_d = timeout_err_q;
        if (state_q == StMul && !row_evt) begin
            wd_d = wd_q + WD_W'(1);
        end
        if (start_acc) begin
            timeout_err_d = 1'b0;
        end
        if (timeout_hit) begin
            timeout_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wd_q          <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wd_q          <= wd_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        rows_m1_d = rows_m1_q;
        cfg_err_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (data_stored) begin
                    if (start_ok) begin
                        rows_m1_d = row_count - ADDR_W'(1);
                        state_d   = StArm;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            StArm:      state_d = StMul;
            StMul:      if (row_evt && last_row) state_d = StMulDone;
            StMulDone:  state_d = StWriteOut;
            StWriteOut: if (out_ack) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
        // Cancellation outranks row completion and acknowledge.
        if (state_q != StIdle && (abort || timeout_hit)) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= StIdle;
            rows_m1_q <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rows_m1_q <= rows_m1_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign res_add    = (state_q == StMul) ? row_idx : '0;
    assign begin_mult = (state_q == StMul);
    assign done_calc  = (state_q == StWriteOut);
    assign busy       = (state_q != StIdle);
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_seq_main_controller.sv
// Scoreboard bench for seq_main_controller; set SEQ_MAIN_CTRL_ROW_TIMEOUT_EN for the watchdog case.
module tb_seq_main_controller;

    localparam int EV_ROW  = 0;
    localparam int EV_DONE = 1;
    localparam int EV_CFG  = 2;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       data_stored = 1'b0;
    logic [3:0] row_count = 4'd0;
    logic       done_row = 1'b0;
    logic       abort = 1'b0;
    logic       out_ack = 1'b0;
    logic [3:0] res_add;
    logic       begin_mult;
    logic       done_calc;
    logic       busy;
    logic       cfg_err;
`ifdef SEQ_MAIN_CTRL_ROW_TIMEOUT_EN
    logic       timeout_err;
`endif

    int  tests = 0;
    int  fails = 0;
    ev_t exp_q[$];

    logic       prev_bm = 1'b0;
    logic [3:0] prev_ra = 4'd0;
    logic       prev_dc = 1'b0;
    int         dlen = 0;

    seq_main_controller #(
        .MAX_ROWS    (10),
        .ADDR_W      (4),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .data_stored (data_stored),
        .row_count   (row_count),
        .done_row    (done_row),
        .abort       (abort),
        .out_ack     (out_ack),
        .res_add     (res_add),
        .begin_mult  (begin_mult),
        .done_calc   (done_calc),
        .busy        (busy),
        .cfg_err     (cfg_err)
`ifdef SEQ_MAIN_CTRL_ROW_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int ra, input int bm, input int dc,
                              input int bs);
        check({tag, "_res_add"}, int'(res_add), ra);
        check({tag, "_begin_mult"}, int'(begin_mult), bm);
        check({tag, "_done_calc"}, int'(done_calc), dc);
        check({tag, "_busy"}, int'(busy), bs);
    endtask

    task automatic push_ev(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic got_ev(input int kind, input int val, input string name);
        ev_t e;
        if (exp_q.size() == 0) begin
            check({"sb_unexpected_", name}, val, -1);
        end else begin
            e = exp_q.pop_front();
            check({"sb_kind_", name}, kind, e.kind);
            check({"sb_val_", name}, val, e.val);
        end
    endtask

    // Monitor: turns DUT output activity into events and scores them against the queue.
    always @(negedge clk or negedge n_reset) begin
        if (!n_reset) begin
            prev_bm = 1'b0;
            prev_ra = 4'd0;
            prev_dc = 1'b0;
            dlen    = 0;
        end else begin
            if (begin_mult && (!prev_bm || res_add != prev_ra)) got_ev(EV_ROW, int'(res_add), "row");
            if (done_calc) begin
                dlen++;
            end else if (prev_dc) begin
                got_ev(EV_DONE, dlen, "done");
                dlen = 0;
            end
            if (cfg_err) got_ev(EV_CFG, int'(busy), "cfg");
            prev_bm = begin_mult;
            prev_ra = res_add;
            prev_dc = done_calc;
        end
    end

    // All stimulus tasks are entered and left on a falling edge.
    task automatic start_ok(input int rc);
        row_count   = 4'(rc);
        data_stored = 1'b1;
        @(negedge clk);
        data_stored = 1'b0;
        check_outs("arm", 0, 0, 0, 1);
`ifdef SEQ_MAIN_CTRL_ROW_TIMEOUT_EN
        check("arm_timeout_err", int'(timeout_err), 0);
`endif
        @(negedge clk);
        check_outs("mul_first", 0, 1, 0, 1);
    endtask

    task automatic start_bad(input int rc);
        row_count   = 4'(rc);
        data_stored = 1'b1;
        @(negedge clk);
        data_stored = 1'b0;
        check("cfg_err_pulse", int'(cfg_err), 1);
        check("cfg_busy0", int'(busy), 0);
        @(negedge clk);
        check("cfg_err_clear", int'(cfg_err), 0);
        check("cfg_busy1", int'(busy), 0);
    endtask

    task automatic row_pulse();
        done_row = 1'b1;
        @(negedge clk);
        done_row = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0, expected 1");
        $fatal(1, "bench did not finish");
    end

    initial begin
        // Reset state
        #2;
        check_outs("reset", 0, 0, 0, 0);
        check("reset_cfg_err", int'(cfg_err), 0);
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        check_outs("post_reset", 0, 0, 0, 0);

        // Ten rows, single-cycle done_row pulses, immediate acknowledge
        for (int i = 0; i < 10; i++) push_ev(EV_ROW, i);
        push_ev(EV_DONE, 1);
        out_ack = 1'b1;
        start_ok(10);
        for (int i = 0; i < 9; i++) begin
            row_pulse();
            @(negedge clk);
        end
        check("t2_last_addr", int'(res_add), 9);
        row_pulse();
        check_outs("t2_mul_done", 0, 0, 0, 1);
        @(negedge clk);
        check_outs("t2_write_out", 0, 0, 1, 1);
        @(negedge clk);
        check_outs("t2_idle", 0, 0, 0, 0);
        out_ack = 1'b0;

        // Three rows with done_row held 4 cycles; delayed acknowledge
        for (int i = 0; i < 3; i++) push_ev(EV_ROW, i);
        push_ev(EV_DONE, 6);
        start_ok(3);
        for (int r = 0; r < 2; r++) begin
            done_row = 1'b1;
            repeat (4) @(negedge clk);
            done_row = 1'b0;
            @(negedge clk);
        end
        done_row = 1'b1;
        @(negedge clk);
        check_outs("t3_mul_done", 0, 0, 0, 1);
        @(negedge clk);
        for (int k = 1; k <= 6; k++) begin
            check("t3_done_hold", int'(done_calc), 1);
            check("t3_done_addr", int'(res_add), 0);
            if (k == 3) done_row = 1'b0;
            if (k == 6) out_ack = 1'b1;
            @(negedge clk);
        end
        check_outs("t3_idle", 0, 0, 0, 0);
        out_ack = 1'b0;

        // Illegal row counts
        push_ev(EV_CFG, 0);
        push_ev(EV_CFG, 0);
        start_bad(0);
        start_bad(11);

        // Abort coinciding with a row edge, then a normal two-row run
        for (int i = 0; i < 5; i++) push_ev(EV_ROW, i);
        start_ok(6);
        for (int i = 0; i < 4; i++) begin
            row_pulse();
            @(negedge clk);
        end
        check("t5_addr4", int'(res_add), 4);
        abort    = 1'b1;
        done_row = 1'b1;
        @(negedge clk);
        check_outs("t5_abort", 0, 0, 0, 0);
        abort    = 1'b0;
        done_row = 1'b0;
        @(negedge clk);
        push_ev(EV_ROW, 0);
        push_ev(EV_ROW, 1);
        push_ev(EV_DONE, 1);
        out_ack = 1'b1;
        start_ok(2);
        row_pulse();
        @(negedge clk);
        row_pulse();
        check_outs("t5_mul_done", 0, 0, 0, 1);
        @(negedge clk);
        check_outs("t5_write_out", 0, 0, 1, 1);
        @(negedge clk);
        check_outs("t5_idle", 0, 0, 0, 0);
        out_ack = 1'b0;

        // Asynchronous reset in the middle of a run
        for (int i = 0; i < 4; i++) push_ev(EV_ROW, i);
        start_ok(5);
        for (int i = 0; i < 3; i++) begin
            row_pulse();
            @(negedge clk);
        end
        check("t1_addr3", int'(res_add), 3);
        #1 n_reset = 1'b0;
        #1;
        check_outs("t1_async_reset", 0, 0, 0, 0);
        check("t1_cfg_err", int'(cfg_err), 0);
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t1_stay_idle", int'(busy), 0);
        end

`ifdef SEQ_MAIN_CTRL_ROW_TIMEOUT_EN
        // Watchdog: eight MUL cycles without a row edge
        push_ev(EV_ROW, 0);
        start_ok(4);
        for (int c = 2; c <= 8; c++) begin
            @(negedge clk);
            check("t6_mul_hold", int'(begin_mult), 1);
        end
        @(negedge clk);
        check_outs("t6_timeout", 0, 0, 0, 0);
        check("t6_timeout_err", int'(timeout_err), 1);
        @(negedge clk);
        check("t6_timeout_sticky", int'(timeout_err), 1);
        push_ev(EV_ROW, 0);
        push_ev(EV_DONE, 1);
        out_ack = 1'b1;
        start_ok(1);
        row_pulse();
        @(negedge clk);
        @(negedge clk);
        check_outs("t6_idle", 0, 0, 0, 0);
        check("t6_err_cleared", int'(timeout_err), 0);
        out_ack = 1'b0;
`endif

        @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
